headstone_spawner: RTL and testbench

- Producer side of the headstone record interface: watches the pixel stream for a car/pedestrian overlap and captures the first hit in each frame.
- During vertical blank it emits one headstone record: a 22-bit address {x[10:0], y[10:0]} plus a one-cycle strobe f_out.
- Feeds the headstone renderer's f_in/address inputs. Enforces that renderer's rules: address never 0, and address held stable around each strobe.

---
 rtl/headstone_spawner.sv | 129 ++++++++++++
 tb/tb_headstone_spawner.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/headstone_spawner.sv
// rtl/headstone_spawner.sv - captures the first car/pedestrian overlap per frame and emits one headstone record in vblank
// Optional HS_WRAP_EN: remove the spawn-limit DONE state so spawning continues indefinitely.
module headstone_spawner #(
    parameter int OFF_X           = 8,
    parameter int OFF_Y           = 16,
    parameter int MAX_HS          = 8,
    parameter int COOLDOWN_FRAMES = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic        enable_in,
    input  logic        car_pix,
    input  logic        ped_pix,
    output logic [21:0] address_out,
    output logic        f_out,
    output logic [3:0]  spawn_cnt
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PENDING  = 3'd1;
    localparam logic [2:0] S_LOAD     = 3'd2;
    localparam logic [2:0] S_STROBE   = 3'd3;
    localparam logic [2:0] S_COOLDOWN = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam int          CW    = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [10:0] OFFX  = 11'(OFF_X);
    localparam logic [10:0] OFFY  = 11'(OFF_Y);
`ifndef HS_WRAP_EN
    localparam logic [3:0]  LIMIT = 4'(MAX_HS);
`endif

    logic [2:0]    state;
    logic [CW-1:0] cool_cnt;
    logic [10:0]   cap_x;
    logic [10:0]   cap_y;
    logic          vblnk_d;

    logic        vb_rise;
    logic        hit;
    logic [10:0] x_sat;
    logic [10:0] y_sat;
    logic [10:0] y_fix;
    logic [21:0] addr_next;

    assign vb_rise = vblnk_in & ~vblnk_d;
    assign hit     = enable_in & car_pix & ped_pix & ~hblnk_in & ~vblnk_in;

    // Address 0 marks an empty renderer slot, so a fully clamped hit is nudged to y=1.
    always_comb begin
        x_sat     = (cap_x >= OFFX) ? (cap_x - OFFX) : 11'd0;
        y_sat     = (cap_y >= OFFY) ? (cap_y - OFFY) : 11'd0;
        y_fix     = ((x_sat == 11'd0) && (y_sat == 11'd0)) ? 11'd1 : y_sat;
        addr_next = {x_sat, y_fix};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            address_out <= 22'd0;
            f_out       <= 1'b0;
            spawn_cnt   <= 4'd0;
            cool_cnt    <= '0;
            cap_x       <= 11'd0;
            cap_y       <= 11'd0;
            vblnk_d     <= 1'b0;
        end else begin
            vblnk_d <= vblnk_in;
            f_out   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hit) begin
                        cap_x <= hcount_in;
                        cap_y <= vcount_in;
                        state <= S_PENDING;
                    end
                end
                S_PENDING: begin
                    // Address is registered on entry to LOAD so it leads the strobe by a cycle.
                    if (vb_rise) begin
                        address_out <= addr_next;
                        state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    f_out <= 1'b1;
                    if (spawn_cnt != 4'd15) begin
                        spawn_cnt <= spawn_cnt + 4'd1;
                    end
                    state <= S_STROBE;
                end
                S_STROBE: begin
`ifndef HS_WRAP_EN
                    if (spawn_cnt == LIMIT) begin
                        state <= S_DONE;
                    end else
`endif
                    if (COOLDOWN_FRAMES == 0) begin
                        state <= S_IDLE;
                    end else begin
                        cool_cnt <= CW'(COOLDOWN_FRAMES);
                        state    <= S_COOLDOWN;
                    end
                end
                S_COOLDOWN: begin
                    if (vb_rise) begin
                        if (cool_cnt <= CW'(1)) begin
                            cool_cnt <= '0;
                            state    <= S_IDLE;
                        end else begin
                            cool_cnt <= cool_cnt - CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_headstone_spawner.sv
// tb/tb_headstone_spawner.sv - frame-level directed bench for headstone_spawner with a reference model
module tb_headstone_spawner;

`ifdef HS_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] hcount_in = 11'd0;
    logic [10:0] vcount_in = 11'd0;
    logic        hblnk_in = 1'b0;
    logic        vblnk_in = 1'b0;
    logic        enable_in = 1'b0;
    logic        car_pix = 1'b0;
    logic        ped_pix = 1'b0;

    logic [21:0] addr0, addr1;
    logic        f0, f1;
    logic [3:0]  cnt0, cnt1;

    int vectors = 0;
    int errors  = 0;
    int s0 = 0, s1 = 0;
    bit go = 1'b0;

    always #5 clk = ~clk;

    headstone_spawner #(.OFF_X(8), .OFF_Y(16), .MAX_HS(LIMIT), .COOLDOWN_FRAMES(2)) u_dut0 (
        .clk(clk), .reset(reset), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .enable_in(enable_in),
        .car_pix(car_pix), .ped_pix(ped_pix),
        .address_out(addr0), .f_out(f0), .spawn_cnt(cnt0)
    );

    headstone_spawner #(.OFF_X(8), .OFF_Y(16), .MAX_HS(LIMIT), .COOLDOWN_FRAMES(0)) u_dut1 (
        .clk(clk), .reset(reset), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .enable_in(enable_in),
        .car_pix(car_pix), .ped_pix(ped_pix),
        .address_out(addr1), .f_out(f1), .spawn_cnt(cnt1)
    );

    // Model: per instance, the frames still blocked, whether a hit is waiting,
    // and the clock edge at which the record strobe is due.
    int          cd[2]         = '{2, 0};
    bit          m_pend[2]     = '{0, 0};
    int          m_px[2]       = '{0, 0};
    int          m_py[2]       = '{0, 0};
    int          m_block[2]    = '{0, 0};
    bit          m_done[2]     = '{0, 0};
    int          m_cnt[2]      = '{0, 0};
    logic [21:0] m_addr[2]     = '{22'd0, 22'd0};
    longint      m_due[2]      = '{-1, -1};
    bit          m_f[2]        = '{0, 0};
    bit          m_vbd         = 1'b0;
    longint      edge_n        = 0;

    function automatic logic [21:0] hs_addr(input int hc, input int vc);
        int x, y;
        logic [10:0] xs, ys;
        x = (hc >= 8) ? hc - 8 : 0;
        y = (vc >= 16) ? vc - 16 : 0;
        if (x == 0 && y == 0) y = 1;
        xs = x[10:0];
        ys = y[10:0];
        return {xs, ys};
    endfunction

    always @(posedge clk) begin
        bit hit, vbr;
        edge_n++;
        hit = enable_in & car_pix & ped_pix & ~hblnk_in & ~vblnk_in;
        vbr = vblnk_in & ~m_vbd;
        if (!reset) begin
            m_vbd = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_pend[k] = 0; m_block[k] = 0; m_done[k] = 0; m_cnt[k] = 0;
                m_addr[k] = 22'd0; m_due[k] = -1; m_f[k] = 0;
            end
        end else begin
            m_vbd = vblnk_in;
            for (int k = 0; k < 2; k++) begin
                m_f[k] = (edge_n == m_due[k]);
                if (m_f[k]) begin
                    m_cnt[k] = (m_cnt[k] < 15) ? m_cnt[k] + 1 : 15;
                    if (!WRAP && m_cnt[k] == LIMIT) m_done[k] = 1;
                    else m_block[k] = cd[k];
                end
                if (hit && !m_pend[k] && !m_done[k] && m_block[k] == 0) begin
                    m_pend[k] = 1;
                    m_px[k] = int'(hcount_in);
                    m_py[k] = int'(vcount_in);
                end
                if (vbr) begin
                    if (m_pend[k]) begin
                        m_addr[k] = hs_addr(m_px[k], m_py[k]);
                        m_due[k]  = edge_n + 1;
                        m_pend[k] = 0;
                    end else if (m_block[k] > 0) begin
                        m_block[k]--;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [21:0] act, input logic [21:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (go) begin
            chk("addr0", addr0, m_addr[0]);
            chk("f0", {21'd0, f0}, {21'd0, m_f[0]});
            chk("cnt0", {18'd0, cnt0}, 22'(m_cnt[0]));
            chk("addr1", addr1, m_addr[1]);
            chk("f1", {21'd0, f1}, {21'd0, m_f[1]});
            chk("cnt1", {18'd0, cnt1}, 22'(m_cnt[1]));
            if (f0 === 1'b1) s0++;
            if (f1 === 1'b1) s1++;
        end
    end

    task automatic step(input logic [10:0] hc, input logic [10:0] vc, input logic hb,
                        input logic vb, input logic en, input logic car, input logic ped);
        hcount_in = hc; vcount_in = vc; hblnk_in = hb; vblnk_in = vb;
        enable_in = en; car_pix = car; ped_pix = ped;
        @(posedge clk);
        #1;
    endtask

    // One frame: optional hits at two points, plus overlaps in hblank and vblank that must not count.
    task automatic frame(input logic h0, input logic [10:0] x0, input logic [10:0] y0,
                         input logic h1, input logic [10:0] x1, input logic [10:0] y1,
                         input logic en, input logic drop);
        logic en2;
        en2 = drop ? 1'b0 : en;
        for (int i = 0; i < 3; i++) step(11'd10, 11'd10, 0, 0, en, 0, 0);
        step(x0, y0, 0, 0, en, h0, h0);
        step(11'd20, 11'd20, 0, 0, en, 1, 0);
        step(x1, y1, 0, 0, en, h1, h1);
        step(11'd500, 11'd500, 1, 0, en, 1, 1);
        step(11'd30, 11'd30, 0, 0, en2, 0, 1);
        for (int i = 0; i < 6; i++) step(11'd600, 11'd700, 0, 1, en2, 1, 1);
        step(11'd0, 11'd0, 0, 0, en2, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(11'd0, 11'd0, 0, 0, 0, 0, 0);
        step(11'd0, 11'd0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        step(11'd0, 11'd0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int b0, b1;
        step(11'd0, 11'd0, 0, 0, 0, 0, 0);
        go = 1'b1;
        do_reset();
        chk("rst_addr0", addr0, 22'd0);
        chk("rst_cnt1", {18'd0, cnt1}, 22'd0);
        chk("rst_f1", {21'd0, f1}, 22'd0);

        // Single hit mid-frame
        frame(1, 11'd200, 11'd300, 0, 11'd0, 11'd0, 1, 0);
        chk("t1_addr", addr1, {11'd192, 11'd284});
        chk("t1_model", m_addr[1], {11'd192, 11'd284});
        chk("t1_cnt", {18'd0, cnt1}, 22'd1);
        chk("t1_strobes", 22'(s1), 22'd1);

        // Only the first of two hits counts
        frame(1, 11'd100, 11'd100, 1, 11'd400, 11'd400, 1, 0);
        chk("t2_addr", addr1, {11'd92, 11'd84});
        chk("t2_strobes", 22'(s1), 22'd2);

        // Clamped to zero, forced non-zero
        frame(1, 11'd3, 11'd5, 0, 11'd0, 11'd0, 1, 0);
        chk("t3_addr", addr1, 22'h000001);

        // Disabled hit ignored; captured hit survives enable dropping
        frame(1, 11'd50, 11'd60, 0, 11'd0, 11'd0, 0, 0);
        chk("en_off_strobes", 22'(s1), 22'd3);
        frame(1, 11'd50, 11'd60, 0, 11'd0, 11'd0, 1, 1);
        chk("en_drop_addr", addr1, {11'd42, 11'd44});
        chk("en_drop_cnt", {18'd0, cnt1}, 22'd4);

        // Cooldown of two frames
        do_reset();
        b0 = s0;
        for (int f = 0; f < 4; f++) frame(1, 11'd200, 11'd300, 0, 11'd0, 11'd0, 1, 0);
        chk("t4_strobes0", 22'(s0 - b0), 22'd2);
        chk("t4_cnt0", {18'd0, cnt0}, 22'd2);

        // Spawn limit versus wrap
        do_reset();
        b0 = s0; b1 = s1;
        for (int f = 0; f < 10; f++) frame(1, 11'd120, 11'd80, 0, 11'd0, 11'd0, 1, 0);
        chk("t5_strobes1", 22'(s1 - b1), WRAP ? 22'd10 : 22'd8);
        chk("t5_cnt1", {18'd0, cnt1}, WRAP ? 22'd10 : 22'd8);
        chk("t5_addr1", addr1, {11'd112, 11'd64});
        chk("t5_strobes0", 22'(s0 - b0), 22'd4);

        // Reset during LOAD
        do_reset();
        step(11'd200, 11'd300, 0, 0, 1, 1, 1);
        step(11'd10, 11'd10, 0, 0, 1, 0, 0);
        step(11'd600, 11'd700, 0, 1, 1, 0, 0);
        reset = 1'b0;
        step(11'd600, 11'd700, 0, 1, 1, 0, 0);
        chk("t6_f1", {21'd0, f1}, 22'd0);
        chk("t6_addr1", addr1, 22'd0);
        chk("t6_cnt1", {18'd0, cnt1}, 22'd0);
        reset = 1'b1;
        b1 = s1;
        for (int i = 0; i < 5; i++) step(11'd600, 11'd700, 0, 1, 1, 0, 0);
        step(11'd0, 11'd0, 0, 0, 1, 0, 0);
        frame(0, 11'd0, 11'd0, 0, 11'd0, 11'd0, 1, 0);
        chk("t6_strobes", 22'(s1 - b1), 22'd0);

        go = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
